// File: rtl/param_delay_sum_beamformer_if.sv
// Stream handshake bundle for the delay-and-sum beamformer: sample capture in, summed points out.
interface param_delay_sum_beamformer_if #(
  parameter int unsigned NCH = 8,
  parameter int unsigned SW  = 16,
  parameter int unsigned OW  = SW + $clog2(NCH)
);
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [NCH*SW-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [OW-1:0]     m_data;

  // Beamformer side
  modport slave (
    input  s_valid, s_last, s_data, m_ready,
    output s_ready, m_valid, m_last, m_data
  );

  // Source / sink side
  modport master (
    output s_valid, s_last, s_data, m_ready,
    input  s_ready, m_valid, m_last, m_data
  );
endinterface

// File: rtl/param_delay_sum_beamformer.sv
// Delay-and-sum beamformer: captures one multichannel frame, then for each focal point sums
// each enabled channel's sample at a ROM-supplied per-channel delay index.
module param_delay_sum_beamformer #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned SW    = 16,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned NPTS  = 540,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = (NPTS > 1) ? $clog2(NPTS) : 1,
  localparam int unsigned OW   = SW + $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NCH-1:0]      ch_mask,
  param_delay_sum_beamformer_if.slave bus,
  output logic [PW-1:0]       dly_addr,
  input  logic [NCH*AW-1:0]   dly_data,
  output logic                busy,
  output logic                done
);

  localparam int unsigned NW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_READ,
    S_SUM,
    S_OUT
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [PW-1:0]            r_pt;
  logic [AW-1:0]            r_wr_ptr;
  logic [NW-1:0]            r_nsamp;
  logic [NCH-1:0]           r_mask;
  logic [NCH-1:0][AW-1:0]   r_idx;
  logic [OW-1:0]            r_m_data;
  logic                     r_m_last;
  logic                     r_s_ready;
  logic                     r_m_valid;
  logic                     r_busy;
  logic                     r_done;

  logic [NCH-1:0][AW-1:0]   w_idx;
  logic [NCH-1:0][OW-1:0]   w_term;
  logic [OW-1:0]            w_sum;
  logic                     w_wr_en;
  logic                     w_load_end;
  logic                     w_pt_last;
  logic                     w_out_fire;

  assign w_idx      = dly_data;
  assign w_wr_en    = (r_state == S_LOAD) && bus.s_valid;
  assign w_load_end = w_wr_en && (bus.s_last || (r_wr_ptr == AW'(DEPTH - 1)));
  assign w_pt_last  = (r_pt == PW'(NPTS - 1));
  assign w_out_fire = (r_state == S_OUT) && bus.m_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_load_end) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_SUM;
      S_SUM:   w_state_nxt = S_OUT;
      S_OUT:   if (bus.m_ready) w_state_nxt = w_pt_last ? S_IDLE : S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control/datapath registers; handshake flags follow the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pt      <= '0;
      r_wr_ptr  <= '0;
      r_nsamp   <= '0;
      r_mask    <= '0;
      r_idx     <= '0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_s_ready <= (w_state_nxt == S_LOAD);
      r_m_valid <= (w_state_nxt == S_OUT);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_out_fire && w_pt_last;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask   <= ch_mask;
            r_wr_ptr <= '0;
            r_nsamp  <= '0;
            r_pt     <= '0;
          end
        end
        S_LOAD: begin
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_nsamp  <= r_nsamp + NW'(1);
          end
          if (w_load_end) r_pt <= '0;
        end
        S_READ: r_idx <= w_idx;
        S_SUM: begin
          r_m_data <= w_sum;
          r_m_last <= w_pt_last;
        end
        S_OUT: if (w_out_fire && !w_pt_last) r_pt <= r_pt + PW'(1);
        default: ;
      endcase
    end
  end

  // Per-channel sample memory, read at that channel's own delay index
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [SW-1:0] r_mem [DEPTH];
    logic [SW-1:0] r_rd;

    always_ff @(posedge clk) begin
      if (w_wr_en)             r_mem[r_wr_ptr] <= bus.s_data[k*SW +: SW];
      if (r_state == S_READ)   r_rd <= r_mem[w_idx[k]];
    end

    // Masked channels and indices past the captured length contribute nothing
    assign w_term[k] = (r_mask[k] && ({1'b0, r_idx[k]} < r_nsamp)) ? OW'($signed(r_rd)) : '0;
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < NCH; k++) w_sum = w_sum + w_term[k];
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_last  = r_m_last;
  assign bus.m_data  = r_m_data;
  assign dly_addr    = r_pt;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_param_delay_sum_beamformer.sv
// Bench for the delay-and-sum beamformer: randomized frames against a behavioural sum model,
// plus directed frames with hand-computed results.
module tb_param_delay_sum_beamformer;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NPTS  = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned OW    = 18;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [NCH-1:0]    ch_mask = '0;
  logic [PW-1:0]     dly_addr;
  logic [NCH*AW-1:0] dly_data = '0;
  logic              busy;
  logic              done;

  param_delay_sum_beamformer_if #(.NCH(NCH), .SW(SW), .OW(OW)) bus ();

  param_delay_sum_beamformer #(.NCH(NCH), .SW(SW), .DEPTH(DEPTH), .NPTS(NPTS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ch_mask  (ch_mask),
    .bus      (bus),
    .dly_addr (dly_addr),
    .dly_data (dly_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [SW-1:0]  cap     [NCH][DEPTH];
  logic [AW-1:0]  dly_tbl [NPTS][NCH];
  logic [NCH-1:0] cur_mask = '0;
  int             exp_val [NPTS];
  int             seen    [NPTS];
  int             mon_pt   = 0;
  int             done_cnt = 0;
  int             rdy_mode = 0;
  bit             pend     = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: each point is the plain signed sum of enabled channels whose delay lands inside the capture
  function automatic void build_exp(input int n);
    for (int p = 0; p < int'(NPTS); p++) begin
      int s = 0;
      for (int k = 0; k < int'(NCH); k++)
        if (cur_mask[k] && int'(dly_tbl[p][k]) < n)
          s += int'($signed(cap[k][dly_tbl[p][k]]));
      exp_val[p] = s;
    end
  endfunction

  // Registered delay ROM: data follows the address by one clock
  always @(posedge clk)
    for (int k = 0; k < int'(NCH); k++) dly_data[k*AW +: AW] <= dly_tbl[dly_addr][k];

  // Output sink readiness
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Compare process: every cycle an output is presented it must match the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_pt = 0;
        pend   = 0;
      end else begin
        if (pend) check("m_valid_held", int'(bus.m_valid), 1);
        if (bus.m_valid) begin
          if (mon_pt >= int'(NPTS)) check("extra_output", mon_pt, int'(NPTS) - 1);
          else begin
            check("m_data", int'($signed(bus.m_data)), exp_val[mon_pt]);
            check("m_last", int'(bus.m_last), int'(mon_pt == int'(NPTS) - 1));
            check("dly_addr_out", int'(dly_addr), mon_pt);
            check("s_ready_in_out", int'(bus.s_ready), 0);
            if (bus.m_ready) seen[mon_pt] = int'($signed(bus.m_data));
          end
          if (bus.m_ready) mon_pt++;
          pend = !bus.m_ready;
        end else pend = 0;
        if (done) begin
          check("done_after_last", mon_pt, int'(NPTS));
          mon_pt = 0;
          done_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_frame(input logic [NCH-1:0] mask, input int n, input bit use_last,
                            input bit rnd_gap, input bit poke);
    int to;
    cur_mask = mask;
    build_exp(n);
    start = 1'b1; ch_mask = mask;
    tick();
    start = 1'b0; ch_mask = ~mask;
    for (int i = 0; i < n; i++) begin
      if (rnd_gap)
        while ($urandom_range(0, 3) == 0) begin bus.s_valid = 1'b0; tick(); end
      bus.s_valid = 1'b1;
      bus.s_last  = use_last && (i == n - 1);
      for (int k = 0; k < int'(NCH); k++) bus.s_data[k*SW +: SW] = cap[k][i];
      if (poke && i == 2) begin start = 1'b1; ch_mask = 4'hF; end
      to = 0;
      do begin @(negedge clk); to++; end while (!bus.s_ready && to < 50);
      check("s_ready_beat", int'(bus.s_ready), 1);
      tick();
      start = 1'b0; ch_mask = ~mask;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    @(negedge clk);
    check("s_ready_after_last", int'(bus.s_ready), 0);
  endtask

  task automatic finish_frame(input int d0, input bit hold, input bit poke);
    int to;
    logic [OW-1:0] held;
    if (hold || poke) begin
      to = 0;
      while (!bus.m_valid && to < 50) begin @(negedge clk); to++; end
      check("first_m_valid", int'(bus.m_valid), 1);
      if (poke) begin
        start = 1'b1; ch_mask = 4'hF;
        tick();
        start = 1'b0;
      end
      if (hold) begin
        held = bus.m_data;
        repeat (10) @(negedge clk);
        check("hold_m_valid", int'(bus.m_valid), 1);
        check("hold_m_data", int'(bus.m_data), int'(held));
        check("hold_dly_addr", int'(dly_addr), 0);
      end
      rdy_mode = 0;
    end
    to = 0;
    while (done_cnt == d0 && to < 400) begin @(negedge clk); to++; end
    check("done_pulse", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("idle_busy", int'(busy), 0);
  endtask

  task automatic run_frame(input logic [NCH-1:0] mask, input int n, input bit use_last,
                           input bit rnd_gap, input bit hold, input bit poke);
    int d0 = done_cnt;
    if (hold || poke) rdy_mode = 2;
    load_frame(mask, n, use_last, rnd_gap, poke);
    finish_frame(d0, hold, poke);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < int'(NCH); k++)
      for (int n = 0; n < int'(DEPTH); n++) cap[k][n] = SW'($urandom);
  endtask

  task automatic fill_dly(input int maxd);
    for (int p = 0; p < int'(NPTS); p++)
      for (int k = 0; k < int'(NCH); k++) dly_tbl[p][k] = AW'($urandom_range(0, maxd));
  endtask

  initial begin
    int d0, to, n;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    for (int p = 0; p < int'(NPTS); p++) begin exp_val[p] = 0; seen[p] = 0; end
    fill_dly(15);

    // Reset values
    repeat (2) tick();
    @(negedge clk);
    check("rst_s_ready", int'(bus.s_ready), 0);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_m_last", int'(bus.m_last), 0);
    check("rst_m_data", int'(bus.m_data), 0);
    check("rst_dly_addr", int'(dly_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    tick();

    // Full-depth capture, all delays 5
    for (int k = 0; k < int'(NCH); k++)
      for (int i = 0; i < int'(DEPTH); i++) cap[k][i] = SW'(100 * k + i);
    for (int p = 0; p < int'(NPTS); p++)
      for (int k = 0; k < int'(NCH); k++) dly_tbl[p][k] = AW'(5);
    rdy_mode = 0;
    run_frame(4'hF, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_pt0", seen[0], 620);
    check("full_pt3", seen[3], 620);

    // Early s_last after 6 beats; channel 3 out of range on the first two points
    for (int p = 0; p < int'(NPTS); p++)
      for (int k = 0; k < int'(NCH); k++) dly_tbl[p][k] = AW'((p < 2 && k == 3) ? 9 : 5);
    run_frame(4'hF, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    check("early_pt0", seen[0], 315);
    check("early_pt2", seen[2], 620);

    // Extremes
    for (int k = 0; k < int'(NCH); k++)
      for (int i = 0; i < int'(DEPTH); i++) cap[k][i] = 16'h8000;
    fill_dly(7);
    run_frame(4'hF, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("neg_ext", seen[1], -131072);
    for (int k = 0; k < int'(NCH); k++)
      for (int i = 0; i < int'(DEPTH); i++) cap[k][i] = 16'h7FFF;
    run_frame(4'hF, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pos_ext", seen[2], 131068);

    // Output backpressure for 10 cycles
    fill_rand();
    fill_dly(11);
    run_frame(4'hF, 12, 1'b1, 1'b0, 1'b1, 1'b0);

    // Partial mask, with start pulses during LOAD and OUT
    for (int k = 0; k < int'(NCH); k++)
      for (int i = 0; i < int'(DEPTH); i++) cap[k][i] = SW'(k + 1);
    fill_dly(7);
    run_frame(4'b0101, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    check("mask_pt0", seen[0], 4);
    check("mask_pt3", seen[3], 4);

    // Reset during SUM of point 2
    fill_rand();
    fill_dly(9);
    d0 = done_cnt;
    load_frame(4'hF, 10, 1'b1, 1'b0, 1'b0);
    to = 0;
    while (!(bus.m_valid && dly_addr == PW'(1)) && to < 100) begin @(negedge clk); to++; end
    check("reach_pt1", int'(dly_addr), 1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_busy_now", int'(busy), 0);
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_m_valid", int'(bus.m_valid), 0);
    check("midrst_dly_addr", int'(dly_addr), 0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    fill_rand();
    fill_dly(15);
    run_frame(4'hF, 16, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized frames under random backpressure
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      fill_rand();
      fill_dly(15);
      n = $urandom_range(1, 16);
      run_frame(NCH'($urandom), n, (n < 16) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/param_delay_sum_beamformer.md
PARAM_DELAY_SUM_BEAMFORMER -- requirements
Module: param_delay_sum_beamformer

Interface
REQ-001 SHALL have parameter NCH, default 8, number of receive channels (>=2).
REQ-002 SHALL have parameter SW, default 16, signed sample width per channel.
REQ-003 SHALL have parameter DEPTH, default 2048, samples stored per channel (power of 2); AW=clog2(DEPTH).
REQ-004 SHALL have parameter NPTS, default 540, focal points per frame; PW=clog2(NPTS); OW=SW+clog2(NCH).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle frame start request.
REQ-008 SHALL have port ch_mask  input  NCH  per-channel enable, sampled on accepted start.
REQ-009 SHALL have ports s_valid/s_ready/s_last  in/out/in  1 each  sample-stream handshake; s_last marks final capture word.
REQ-010 SHALL have port s_data  input  NCH*SW  channel k in bits [k*SW +: SW].
REQ-011 SHALL have port dly_addr  output  PW  focal-point index to external delay ROM.
REQ-012 SHALL have port dly_data  input  NCH*AW  per-channel sample index, valid exactly 1 cycle after dly_addr changes.
REQ-013 SHALL have ports m_valid/m_ready/m_last  out/in/out  1 each  summed-output handshake; m_last on point NPTS-1.
REQ-014 SHALL have port m_data  output  OW  signed delay-and-sum result.
REQ-015 SHALL have ports busy, done  output  1 each  frame in progress; one-cycle frame-complete pulse.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> FETCH -> READ -> SUM -> OUT -> (FETCH | IDLE).
REQ-017 IDLE: start=1 -> LOAD, latch ch_mask, wr_ptr=0, nsamp=0; start in any other state SHALL be ignored.
REQ-018 LOAD: s_ready=1; each s_valid&s_ready writes s_data to per-channel memory at wr_ptr, wr_ptr+1.
REQ-019 LOAD SHALL exit to FETCH with pt=0 on the beat that has s_last=1 or wr_ptr=DEPTH-1; nsamp=beats accepted including that beat.
REQ-020 FETCH (1 cycle): dly_addr=pt.
REQ-021 READ (1 cycle): register each channel's index from dly_data; issue synchronous read of each channel memory at its own index.
REQ-022 SUM (1 cycle): sign-extend each read sample to OW, replace by 0 if ch_mask[k]=0 or index>=nsamp, register the sum of all NCH terms.
REQ-023 Arithmetic SHALL be two's complement, full precision OW bits, no saturation, no overflow possible.
REQ-024 OUT: m_valid=1, m_data and m_last held stable until m_ready=1; m_valid SHALL NOT drop before handshake.
REQ-025 On OUT handshake with pt<NPTS-1: pt+1, -> FETCH; with pt=NPTS-1: -> IDLE, done=1 for exactly one cycle.
REQ-026 Per-point latency start-of-FETCH to m_valid SHALL be 3 cycles; minimum 4 cycles/point with m_ready held high.
REQ-027 s_ready SHALL be 0 outside LOAD; m_valid SHALL be 0 outside OUT; busy=1 in every state except IDLE.
REQ-028 dly_addr SHALL hold pt in READ, SUM, OUT so a registered or combinational ROM sees a stable address.
REQ-029 s_valid=0 in LOAD SHALL stall without state change; capture of zero beats SHALL NOT occur (LOAD waits).

Reset
REQ-030 rst=1 SHALL immediately force IDLE, pt=0, wr_ptr=0, nsamp=0, latched mask=0.
REQ-031 During/after reset: s_ready=0, m_valid=0, m_last=0, m_data=0, dly_addr=0, busy=0, done=0.
REQ-032 Reset mid-frame SHALL abandon the frame without done pulse; memory contents need not be cleared.

Verification (bench NCH=4, SW=16, DEPTH=16, NPTS=4)
REQ-033 Full capture: 16 beats, ch k word n = 100*k+n, all delays =5, mask=4'hF -> each m_data=0+100+200+300+20=620, m_last on 4th output only, one done pulse.
REQ-034 Early s_last after 6 beats, channel 3 delay=9 -> channel 3 term zeroed; delay=5 on all -> included; s_ready=0 after 6th beat.
REQ-035 Negative extremes: all samples 16'h8000, mask=F -> m_data=-131072 (OW=18 bits, 18'h20000); all 16'h7FFF -> 131068.
REQ-036 Backpressure: m_ready low 10 cycles in OUT -> m_valid/m_data/m_last stable, dly_addr unchanged, no point skipped.
REQ-037 Mask=4'b0101 with ch k = k+1 -> m_data=1+3=4; start pulsed during LOAD/OUT -> ignored, mask unchanged.
REQ-038 rst asserted in SUM of point 2 -> next cycle busy=0, m_valid=0, no done; new start runs a full clean frame.
